// File: rtl/cand_dispatch.sv
// rtl/cand_dispatch.sv - streams the best N sorter candidates, best-ranked first, over valid/ready
// Optional feature: define CAND_SKIP_ZERO_EN to drop unfilled (all-zero) slots at load time.
module cand_dispatch #(
  parameter int SLOTS = 10,
  parameter int AW    = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SLOTS*AW-1:0] candidate_angle_buffer,
  input  logic                cand_load,
  input  logic [3:0]          cand_num,
  input  logic                cand_ready,
  output logic                cand_valid,
  output logic [11:0]         cand_theta,
  output logic [11:0]         cand_phi,
  output logic [3:0]          cand_rank,
  output logic                cand_last,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;

  state_t              state, state_nxt;
  logic [SLOTS*AW-1:0] snap, snap_nxt, src;
  logic [SLOTS-1:0]    mask, mask_nxt, load_mask, sent_mask, pend;
  logic [3:0]          eff_num, rank_nxt;
  logic [11:0]         theta_nxt, phi_nxt;
  logic [AW-1:0]       pick;
  logic                valid_nxt, last_nxt, busy_nxt, done_nxt;

  function automatic logic [3:0] first_rank(input logic [SLOTS-1:0] m);
    logic [3:0] r;
    r = '0;
    for (int i = SLOTS - 1; i >= 0; i--)
      if (m[i]) r = 4'(i);
    return r;
  endfunction

  // Rank r lives in slot SLOTS-1-r: the sorter keeps its best entry in the top slot.
  function automatic logic [AW-1:0] slot_of(input logic [SLOTS*AW-1:0] b, input logic [3:0] r);
    logic [AW-1:0] s;
    s = '0;
    for (int k = 0; k < SLOTS; k++)
      if (r == 4'(SLOTS - 1 - k)) s = b[AW*k +: AW];
    return s;
  endfunction

  always_comb begin
    eff_num   = (cand_num > 4'(SLOTS)) ? 4'(SLOTS) : cand_num;
    load_mask = '0;
    for (int i = 0; i < SLOTS; i++) begin
      load_mask[i] = (4'(i) < eff_num);
`ifdef CAND_SKIP_ZERO_EN
      if (slot_of(candidate_angle_buffer, 4'(i)) == '0) load_mask[i] = 1'b0;
`endif
    end
    sent_mask = mask & ~(SLOTS'(1) << cand_rank);
  end

  always_comb begin
    state_nxt = state;
    snap_nxt  = snap;
    mask_nxt  = mask;
    valid_nxt = cand_valid;
    theta_nxt = cand_theta;
    phi_nxt   = cand_phi;
    rank_nxt  = cand_rank;
    last_nxt  = cand_last;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    src       = snap;
    pend      = '0;
    pick      = '0;
    unique case (state)
      IDLE: begin
        if (cand_load) begin
          snap_nxt = candidate_angle_buffer;
          mask_nxt = load_mask;
          src      = candidate_angle_buffer;
          pend     = load_mask;
          if (load_mask == '0) begin
            state_nxt = FIN;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = SEND;
            valid_nxt = 1'b1;
            busy_nxt  = 1'b1;
          end
        end
      end
      SEND: begin
        if (cand_valid && cand_ready) begin
          mask_nxt = sent_mask;
          pend     = sent_mask;
          if (sent_mask == '0) begin
            state_nxt = FIN;
            valid_nxt = 1'b0;
            last_nxt  = 1'b0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Preload the next pending rank so consecutive transfers have no bubble.
    if (pend != '0) begin
      rank_nxt  = first_rank(pend);
      pick      = slot_of(src, rank_nxt);
      theta_nxt = pick[23:12];
      phi_nxt   = pick[11:0];
      last_nxt  = ($countones(pend) == 1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      snap       <= '0;
      mask       <= '0;
      cand_valid <= 1'b0;
      cand_theta <= '0;
      cand_phi   <= '0;
      cand_rank  <= '0;
      cand_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      snap       <= snap_nxt;
      mask       <= mask_nxt;
      cand_valid <= valid_nxt;
      cand_theta <= theta_nxt;
      cand_phi   <= phi_nxt;
      cand_rank  <= rank_nxt;
      cand_last  <= last_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

endmodule

// File: tb/tb_cand_dispatch.sv
// tb/tb_cand_dispatch.sv - directed self-checking bench for cand_dispatch
module tb_cand_dispatch;

  logic         clk = 1'b0;
  logic         rst;
  logic [239:0] candidate_angle_buffer;
  logic         cand_load;
  logic [3:0]   cand_num;
  logic         cand_ready;
  logic         cand_valid;
  logic [11:0]  cand_theta;
  logic [11:0]  cand_phi;
  logic [3:0]   cand_rank;
  logic         cand_last;
  logic         busy;
  logic         done;

  logic [23:0]  slot_val [10];
  int           n_cmp = 0;
  int           n_err = 0;

  cand_dispatch dut (
    .clk                    (clk),
    .rst                    (rst),
    .candidate_angle_buffer (candidate_angle_buffer),
    .cand_load              (cand_load),
    .cand_num               (cand_num),
    .cand_ready             (cand_ready),
    .cand_valid             (cand_valid),
    .cand_theta             (cand_theta),
    .cand_phi               (cand_phi),
    .cand_rank              (cand_rank),
    .cand_last              (cand_last),
    .busy                   (busy),
    .done                   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_default();
    for (int k = 0; k < 10; k++) slot_val[k] = {12'(k + 1), 12'(k + 16)};
  endtask

  // Loads with count n; ready is held low for the first `stall` valid cycles.
  task automatic dispatch(input int n, input int stall, input bit reload);
    int exp_r[$];
    int eff, got, cyc, r;
    eff = (n > 10) ? 10 : n;
    for (int i = 0; i < eff; i++) begin
`ifdef CAND_SKIP_ZERO_EN
      if (slot_val[9 - i] == 24'd0) continue;
`endif
      exp_r.push_back(i);
    end
    for (int k = 0; k < 10; k++) candidate_angle_buffer[24*k +: 24] = slot_val[k];
    cand_num   = 4'(n);
    cand_load  = 1'b1;
    cand_ready = 1'b0;
    tick();
    cand_load = 1'b0;
    if (exp_r.size() == 0) begin
      check("empty_done", done, 1);
      check("empty_valid", cand_valid, 0);
      check("empty_busy", busy, 0);
      tick();
      check("empty_done_off", done, 0);
      check("empty_valid2", cand_valid, 0);
      return;
    end
    check("busy_start", busy, 1);
    got = 0;
    cyc = 0;
    while (got < exp_r.size() && cyc < 60) begin
      r = exp_r[got];
      check("valid", cand_valid, 1);
      check("rank", cand_rank, r);
      check("theta", cand_theta, slot_val[9 - r][23:12]);
      check("phi", cand_phi, slot_val[9 - r][11:0]);
      check("last", cand_last, (got == exp_r.size() - 1) ? 1 : 0);
      cand_ready = (cyc >= stall);
      if (reload && cyc == 1) begin
        cand_load = 1'b1;
        cand_num  = 4'd1;
        candidate_angle_buffer = ~candidate_angle_buffer;
      end else begin
        cand_load = 1'b0;
      end
      if (cand_ready) got++;
      tick();
      cyc++;
    end
    cand_load  = 1'b0;
    check("timeout", (cyc < 60) ? 1 : 0, 1);
    check("done_pulse", done, 1);
    check("valid_end", cand_valid, 0);
    check("busy_end", busy, 0);
    check("last_end", cand_last, 0);
    cand_ready = 1'b0;
    tick();
    check("done_off", done, 0);
    check("valid_idle", cand_valid, 0);
  endtask

  initial begin
    rst = 1'b0;
    candidate_angle_buffer = '0;
    cand_load  = 1'b0;
    cand_num   = '0;
    cand_ready = 1'b0;
    fill_default();
    #1;
    check("rst_valid", cand_valid, 0);
    check("rst_theta", cand_theta, 0);
    check("rst_phi", cand_phi, 0);
    check("rst_rank", cand_rank, 0);
    check("rst_last", cand_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    dispatch(3, 0, 1'b0);
    dispatch(2, 3, 1'b1);
    dispatch(15, 0, 1'b0);
    dispatch(0, 0, 1'b0);

    // Abandon a dispatch mid-SEND with the consumer stalled.
    for (int k = 0; k < 10; k++) candidate_angle_buffer[24*k +: 24] = slot_val[k];
    cand_num  = 4'd5;
    cand_load = 1'b1;
    tick();
    cand_load = 1'b0;
    tick();
    check("pre_rst_valid", cand_valid, 1);
    rst = 1'b0;
    #1;
    check("arst_valid", cand_valid, 0);
    check("arst_theta", cand_theta, 0);
    check("arst_phi", cand_phi, 0);
    check("arst_rank", cand_rank, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    tick();
    tick();
    check("arst_done_hold", done, 0);
    rst = 1'b1;
    tick();
    check("post_rst_done", done, 0);
    dispatch(3, 0, 1'b0);

    slot_val[8] = 24'd0;
    slot_val[6] = 24'd0;
    dispatch(5, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
